// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared widths and the writeback request record used by the
//                register-file write queue and its bypass lookup logic.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    // Width of one flattened queue entry {addr, data}.
    localparam int RF_WB_W     = RF_ADDR_W + RF_DATA_W;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wq_match.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wq_match
//  Description : One bypass lookup port. Searches every occupied queue entry
//                for a non-zero register index and returns the data of the
//                youngest matching entry.
//  Ports       : entries_i  flattened queue storage, entry i at slice i
//                head_i     index of the oldest occupied entry
//                count_i    number of occupied entries
//                addr_i     register index to look up
//                hit_o      a pending value exists for addr_i
//                data_o     youngest pending value, 0 when no hit
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wq_match
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH*RF_WB_W-1:0]   entries_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [$clog2(DEPTH):0]     count_i,
    input  logic [RF_ADDR_W-1:0]       addr_i,
    output logic                       hit_o,
    output logic [RF_DATA_W-1:0]       data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t [DEPTH-1:0] w_entries;
    logic    [PTR_W-1:0] w_idx;

    assign w_entries = entries_i;

    // Walk entries from oldest to youngest; a later match overrides an
    // earlier one, so the final value is the youngest match.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) && (addr_i != '0) &&
                (w_entries[w_idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = w_entries[w_idx].data;
            end
        end
    end

endmodule : rf_wq_match
`default_nettype wire

// File: rtl/rf_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_queue
//  Description : In-order writeback FIFO in front of the single write port of
//                the 32x32 register file. Accepts requests over valid/ready,
//                retires at most one per cycle, and optionally exposes two
//                bypass lookup ports over the pending entries.
//  Config      : RF_WQ_BYPASS_EN  defined   -> lookup logic implemented
//                                 undefined -> lookup outputs tied to 0
//  Ports       : clk_i, rst_ni            clock, async active-low reset
//                in_valid_i/in_ready_o    request handshake
//                in_addr_i/in_data_i      request payload (addr 0 discarded)
//                rf_stall_i               hold the head entry
//                rf_we_o/rf_waddr_o/rf_wdata_o  register-file write port
//                lookupN_addr_i/hit_o/data_o    bypass lookups (N = 1, 2)
//                count_o                  occupied entries
//  Revision    : 1.0  initial release
// ============================================================================
module rf_write_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [RF_ADDR_W-1:0]       in_addr_i,
    input  logic [RF_DATA_W-1:0]       in_data_i,
    input  logic                       rf_stall_i,
    output logic                       rf_we_o,
    output logic [RF_ADDR_W-1:0]       rf_waddr_o,
    output logic [RF_DATA_W-1:0]       rf_wdata_o,
    input  logic [RF_ADDR_W-1:0]       lookup1_addr_i,
    input  logic [RF_ADDR_W-1:0]       lookup2_addr_i,
    output logic                       lookup1_hit_o,
    output logic                       lookup2_hit_o,
    output logic [RF_DATA_W-1:0]       lookup1_data_o,
    output logic [RF_DATA_W-1:0]       lookup2_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    wb_req_t [DEPTH-1:0] mem_q, mem_d;

    logic    w_push;
    logic    w_pop;
    logic    w_empty;
    wb_req_t w_head;

    assign w_empty = (count_q == '0);
    assign w_head  = mem_q[head_q];

    // Full queue never accepts, even when the head retires this cycle.
    // rst_ni is folded in so the handshake is closed during reset.
    assign in_ready_o = rst_ni && (count_q < c_depth);

    // Address 0 completes the handshake but never allocates an entry.
    assign w_push = in_valid_i && in_ready_o && (in_addr_i != '0);

    assign rf_we_o    = !w_empty && !rf_stall_i;
    assign w_pop      = rf_we_o;
    assign rf_waddr_o = w_empty ? '0 : w_head.addr;
    assign rf_wdata_o = w_empty ? '0 : w_head.data;
    assign count_o    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;

        if (w_push) begin
            mem_d[tail_q] = '{addr: in_addr_i, data: in_data_i};
            tail_d        = tail_q + 1'b1;
        end

        if (w_pop) begin
            head_d = head_q + 1'b1;
        end

        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left out of reset; occupancy is
    // tracked entirely by count_q, so stale contents are never observable.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef RF_WQ_BYPASS_EN
    generate
        if (1) begin : g_bypass
            rf_wq_match #(
                .DEPTH     (DEPTH)
            ) u_match1 (
                .entries_i (mem_q),
                .head_i    (head_q),
                .count_i   (count_q),
                .addr_i    (lookup1_addr_i),
                .hit_o     (lookup1_hit_o),
                .data_o    (lookup1_data_o)
            );

            rf_wq_match #(
                .DEPTH     (DEPTH)
            ) u_match2 (
                .entries_i (mem_q),
                .head_i    (head_q),
                .count_i   (count_q),
                .addr_i    (lookup2_addr_i),
                .hit_o     (lookup2_hit_o),
                .data_o    (lookup2_data_o)
            );
        end
    endgenerate
`else
    // Lookup ports stay on the boundary so both builds share one interface.
    logic w_unused_lookup;
    assign w_unused_lookup = ^{lookup1_addr_i, lookup2_addr_i};

    assign lookup1_hit_o  = 1'b0;
    assign lookup2_hit_o  = 1'b0;
    assign lookup1_data_o = '0;
    assign lookup2_data_o = '0;
`endif

endmodule : rf_write_queue
`default_nettype wire

// File: tb/tb_rf_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_write_queue
//  Description : Directed self-checking bench for rf_write_queue (DEPTH 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_write_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  in_addr_i;
    logic [31:0] in_data_i;
    logic        rf_stall_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  lookup1_addr_i;
    logic [4:0]  lookup2_addr_i;
    logic        lookup1_hit_o;
    logic        lookup2_hit_o;
    logic [31:0] lookup1_data_o;
    logic [31:0] lookup2_data_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    logic [36:0] exp_q[$];
    logic        exp_ready;
    logic        exp_we;

`ifdef RF_WQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    rf_write_queue #(.DEPTH(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_addr_i      (in_addr_i),
        .in_data_i      (in_data_i),
        .rf_stall_i     (rf_stall_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .lookup1_addr_i (lookup1_addr_i),
        .lookup2_addr_i (lookup2_addr_i),
        .lookup1_hit_o  (lookup1_hit_o),
        .lookup2_hit_o  (lookup2_hit_o),
        .lookup1_data_o (lookup1_data_o),
        .lookup2_data_o (lookup2_data_o),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni         = 1'b0;
        in_valid_i     = 1'b0;
        in_addr_i      = '0;
        in_data_i      = '0;
        rf_stall_i     = 1'b0;
        lookup1_addr_i = '0;
        lookup2_addr_i = '0;

        // ---------------- reset state ----------------
        #3;
        chk("rst_ready", 32'(in_ready_o), 32'd0);
        chk("rst_count", 32'(count_o),    32'd0);
        chk("rst_we",    32'(rf_we_o),    32'd0);
        chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_wdata", rf_wdata_o,      32'd0);
        chk("rst_hit1",  32'(lookup1_hit_o), 32'd0);
        chk("rst_data1", lookup1_data_o,  32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready_o), 32'd1);

        // ---------------- single write latency ----------------
        in_valid_i = 1'b1; in_addr_i = 5'd3; in_data_i = 32'hDEADBEEF;
        #1;
        chk("single_ready", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        #1;
        chk("single_count", 32'(count_o),    32'd1);
        chk("single_we",    32'(rf_we_o),    32'd1);
        chk("single_waddr", 32'(rf_waddr_o), 32'd3);
        chk("single_wdata", rf_wdata_o,      32'hDEADBEEF);
        tick();
        chk("single_count_after", 32'(count_o),    32'd0);
        chk("single_we_after",    32'(rf_we_o),    32'd0);
        chk("single_waddr_after", 32'(rf_waddr_o), 32'd0);
        chk("single_wdata_after", rf_wdata_o,      32'd0);

        // ---------------- address 0 discarded ----------------
        in_valid_i = 1'b1; in_addr_i = 5'd0; in_data_i = 32'h1234;
        #1;
        chk("a0_ready", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        #1;
        chk("a0_count", 32'(count_o), 32'd0);
        chk("a0_we",    32'(rf_we_o), 32'd0);
        tick();
        chk("a0_we2",   32'(rf_we_o), 32'd0);

        // ---------------- fill while stalled, then drain ----------------
        rf_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_addr_i = 5'(10 + i); in_data_i = 32'h100 + 32'(i);
            tick();
            chk("fill_count", 32'(count_o), 32'(i + 1));
        end
        in_valid_i = 1'b0;
        #1;
        chk("full_ready", 32'(in_ready_o), 32'd0);
        chk("full_we",    32'(rf_we_o),    32'd0);
        chk("full_waddr", 32'(rf_waddr_o), 32'd10);
        rf_stall_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_we",    32'(rf_we_o),    32'd1);
            chk("drain_waddr", 32'(rf_waddr_o), 32'(10 + i));
            chk("drain_wdata", rf_wdata_o,      32'h100 + 32'(i));
            tick();
        end
        chk("drain_count", 32'(count_o), 32'd0);
        chk("drain_we_end", 32'(rf_we_o), 32'd0);

        // ---------------- bypass lookups ----------------
        rf_stall_i = 1'b1;
        in_valid_i = 1'b1; in_addr_i = 5'd5; in_data_i = 32'hA;
        tick();
        in_data_i = 32'hB;
        tick();
        in_valid_i = 1'b0;
        lookup1_addr_i = 5'd5; lookup2_addr_i = 5'd6;
        #1;
        chk("byp_hit1",  32'(lookup1_hit_o), 32'(BYP));
        chk("byp_data1", lookup1_data_o,     BYP ? 32'hB : 32'h0);
        chk("byp_hit2",  32'(lookup2_hit_o), 32'd0);
        chk("byp_data2", lookup2_data_o,     32'd0);
        lookup2_addr_i = 5'd0;
        #1;
        chk("byp_hit_a0", 32'(lookup2_hit_o), 32'd0);
        rf_stall_i = 1'b0;
        #1;
        chk("byp_we",        32'(rf_we_o),       32'd1);
        chk("byp_wdata",     rf_wdata_o,         32'hA);
        chk("byp_hit_wr",    32'(lookup1_hit_o), 32'(BYP));
        chk("byp_data_wr",   lookup1_data_o,     BYP ? 32'hB : 32'h0);
        tick();
        chk("byp_count1",    32'(count_o),       32'd1);
        chk("byp_hit_head",  32'(lookup1_hit_o), 32'(BYP));
        chk("byp_data_head", lookup1_data_o,     BYP ? 32'hB : 32'h0);
        chk("byp_wdata2",    rf_wdata_o,         32'hB);
        tick();
        chk("byp_hit_empty",  32'(lookup1_hit_o), 32'd0);
        chk("byp_data_empty", lookup1_data_o,     32'd0);
        lookup1_addr_i = 5'd0;

        // ---------------- full queue with continuous drain, wrap ----------------
        rf_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_addr_i = 5'(20 + i); in_data_i = 32'h200 + 32'(i);
            exp_q.push_back({5'(20 + i), 32'h200 + 32'(i)});
            tick();
        end
        rf_stall_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid_i = 1'b1; in_addr_i = 5'(24 + k); in_data_i = 32'h300 + 32'(k);
            #1;
            exp_ready = (exp_q.size() < 4);
            exp_we    = (exp_q.size() != 0);
            chk("wrap_ready", 32'(in_ready_o), 32'(exp_ready));
            chk("wrap_we",    32'(rf_we_o),    32'(exp_we));
            chk("wrap_waddr", 32'(rf_waddr_o), 32'(exp_q[0][36:32]));
            chk("wrap_wdata", rf_wdata_o,      exp_q[0][31:0]);
            tick();
            if (exp_we)    void'(exp_q.pop_front());
            if (exp_ready) exp_q.push_back({5'(24 + k), 32'h300 + 32'(k)});
        end
        in_valid_i = 1'b0;
        #1;
        while (exp_q.size() != 0) begin
            chk("wrap_tail_we",    32'(rf_we_o),    32'd1);
            chk("wrap_tail_waddr", 32'(rf_waddr_o), 32'(exp_q[0][36:32]));
            chk("wrap_tail_wdata", rf_wdata_o,      exp_q[0][31:0]);
            tick();
            void'(exp_q.pop_front());
        end
        chk("wrap_count_end", 32'(count_o), 32'd0);

        // ---------------- asynchronous reset mid-operation ----------------
        rf_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_addr_i = 5'(7 + i); in_data_i = 32'h700 + 32'(i);
            tick();
        end
        in_valid_i = 1'b0;
        #1;
        chk("mid_count", 32'(count_o), 32'd3);
        rf_stall_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count_o),    32'd0);
        chk("mid_rst_we",    32'(rf_we_o),    32'd0);
        chk("mid_rst_ready", 32'(in_ready_o), 32'd0);
        chk("mid_rst_waddr", 32'(rf_waddr_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_we",    32'(rf_we_o), 32'd0);
            chk("post_rst_count", 32'(count_o), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_write_queue
`default_nettype wire
